// File: rtl/fsmc_sync_slave_if.sv
// ---------------------------------------------------------------------------
// fsmc_sync_slave_if
//   Bundles the STM32 FSMC pin-side signals and the register-decoder side
//   signals of fsmc_sync_slave into one interface.
//
//   FSMC pins (async)  : aNE, aNOE, aNWE (active low), aA, aD_in
//   Pad drive          : d_oe, d_out (to SB_IO OUTPUT_ENABLE / D_OUT_0)
//   Decoder side       : r_adr, do_read, r_data (combinational from r_adr),
//                        w_adr, w_data, do_write
//   Status             : proto_err (1-cycle pulse on illegal strobe combo)
//
//   Modports:
//     slave  - the FSMC slave block itself
//     master - the environment (pins + decoder) around the slave
// ---------------------------------------------------------------------------
interface fsmc_sync_slave_if #(
    parameter int ADRW = 8,
    parameter int DATW = 16
);
    logic            aNE;
    logic            aNOE;
    logic            aNWE;
    logic [ADRW-1:0] aA;
    logic [DATW-1:0] aD_in;
    logic [ADRW-1:0] r_adr;
    logic [ADRW-1:0] w_adr;
    logic            do_read;
    logic [DATW-1:0] r_data;
    logic            do_write;
    logic [DATW-1:0] w_data;
    logic            d_oe;
    logic [DATW-1:0] d_out;
    logic            proto_err;

    modport slave (
        input  aNE, aNOE, aNWE, aA, aD_in, r_data,
        output r_adr, w_adr, do_read, do_write, w_data, d_oe, d_out, proto_err
    );

    modport master (
        output aNE, aNOE, aNWE, aA, aD_in, r_data,
        input  r_adr, w_adr, do_read, do_write, w_data, d_oe, d_out, proto_err
    );
endinterface

// File: rtl/fsmc_sync_slave.sv
// ---------------------------------------------------------------------------
// fsmc_sync_slave
//   Asynchronous STM32 FSMC (NOR/SRAM, non-multiplexed) slave clocked on the
//   PLL clock. The async strobes, address and data are synchronised through
//   equal-depth flop chains, and each bus cycle becomes a single-cycle
//   do_write or do_read strobe for the register decoder. Read data is driven
//   back onto the tristate pads via d_oe/d_out.
//
//   Ports:
//     clk  - system clock (PLL)
//     rst  - synchronous, active-high reset
//     bus  - fsmc_sync_slave_if.slave (pins, pad drive, decoder side)
//
//   Parameters:
//     ADRW, DATW   - address / data widths (must match the interface)
//     SYNC_STAGES  - synchroniser depth (>= 2), same for ctrl, addr, data
// ---------------------------------------------------------------------------
module fsmc_sync_slave #(
    parameter int ADRW        = 8,
    parameter int DATW        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fsmc_sync_slave_if.slave     bus
);

    typedef enum logic [1:0] {IDLE, WR, RD, WAIT_REL} state_e;

    // Counts cycles since reset release so the first cycle with real
    // synchronised strobes can be recognised (presets are not bus state).
    localparam int BOOT_W = $clog2(SYNC_STAGES + 2);

    // ---------------- synchronisers ----------------
    logic [SYNC_STAGES-1:0] ne_sync_q, noe_sync_q, nwe_sync_q;
    logic [ADRW-1:0]        a_sync_q [SYNC_STAGES];
    logic [DATW-1:0]        d_sync_q [SYNC_STAGES];

    logic            s_ne, s_noe, s_nwe;
    logic [ADRW-1:0] s_a;
    logic [DATW-1:0] s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: these chains are plain flops, not RAM, so resetting every
            // stage is cheap and keeps the strobes deasserted after reset.
            ne_sync_q  <= '1;
            noe_sync_q <= '1;
            nwe_sync_q <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                a_sync_q[i] <= '0;
                d_sync_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every stage samples the value
            // its predecessor held before this edge.
            ne_sync_q   <= {ne_sync_q[SYNC_STAGES-2:0],  bus.aNE};
            noe_sync_q  <= {noe_sync_q[SYNC_STAGES-2:0], bus.aNOE};
            nwe_sync_q  <= {nwe_sync_q[SYNC_STAGES-2:0], bus.aNWE};
            a_sync_q[0] <= bus.aA;
            d_sync_q[0] <= bus.aD_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                a_sync_q[i] <= a_sync_q[i-1];
                d_sync_q[i] <= d_sync_q[i-1];
            end
        end
    end

    assign s_ne  = ne_sync_q[SYNC_STAGES-1];
    assign s_noe = noe_sync_q[SYNC_STAGES-1];
    assign s_nwe = nwe_sync_q[SYNC_STAGES-1];
    assign s_a   = a_sync_q[SYNC_STAGES-1];
    assign s_d   = d_sync_q[SYNC_STAGES-1];

    // ---------------- state ----------------
    state_e          state_q, state_d;
    logic [BOOT_W-1:0] boot_q;
    logic            first_real;
    logic [ADRW-1:0] wa_q, wa_d;
    logic [DATW-1:0] wd_q, wd_d;
    logic [ADRW-1:0] w_adr_q, w_adr_d, r_adr_q, r_adr_d;
    logic [DATW-1:0] w_data_q, w_data_d, d_out_q, d_out_d;
    logic            do_write_q, do_write_d;
    logic            rd_entry_q, rd_entry_d;
    logic            do_read_q;
    logic            proto_err_q, proto_err_d;
    logic            d_oe_q, d_oe_d;

    assign first_real = (boot_q == BOOT_W'(SYNC_STAGES));

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d     = state_q;
        wa_d        = wa_q;
        wd_d        = wd_q;
        w_adr_d     = w_adr_q;
        w_data_d    = w_data_q;
        r_adr_d     = r_adr_q;
        d_out_d     = d_out_q;
        d_oe_d      = d_oe_q;
        do_write_d  = 1'b0;
        rd_entry_d  = 1'b0;
        proto_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                d_oe_d = 1'b0;
                if (first_real && !(s_ne && s_noe && s_nwe)) begin
                    // Reset released mid-cycle: wait for the bus to go idle
                    // rather than commit a partial cycle.
                    state_d = WAIT_REL;
                end else if (!s_ne) begin
                    if (!s_nwe && !s_noe) begin
                        proto_err_d = 1'b1;
                        state_d     = WAIT_REL;
                    end else if (!s_nwe) begin
                        wa_d    = s_a;
                        wd_d    = s_d;
                        state_d = WR;
                    end else if (!s_noe) begin
                        r_adr_d    = s_a;
                        rd_entry_d = 1'b1;
                        d_oe_d     = 1'b1;
                        state_d    = RD;
                    end
                end
            end
            WR: begin
                if (!s_noe) begin
                    proto_err_d = 1'b1;
                    state_d     = WAIT_REL;
                end else if (s_nwe || s_ne) begin
                    // wa/wd still hold the last sample taken with s_NWE low.
                    w_adr_d    = wa_q;
                    w_data_d   = wd_q;
                    do_write_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    wa_d = s_a;
                    wd_d = s_d;
                end
            end
            RD: begin
                d_out_d = bus.r_data;
                if (!s_nwe) begin
                    proto_err_d = 1'b1;
                    d_oe_d      = 1'b0;
                    state_d     = WAIT_REL;
                end else if (s_noe || s_ne) begin
                    d_oe_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    d_oe_d = 1'b1;
                end
            end
            WAIT_REL: begin
                d_oe_d = 1'b0;
                if (s_ne && s_noe && s_nwe) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            boot_q      <= '0;
            wa_q        <= '0;
            wd_q        <= '0;
            w_adr_q     <= '0;
            w_data_q    <= '0;
            r_adr_q     <= '0;
            d_out_q     <= '0;
            d_oe_q      <= 1'b0;
            do_write_q  <= 1'b0;
            rd_entry_q  <= 1'b0;
            do_read_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (boot_q != BOOT_W'(SYNC_STAGES + 1)) begin
                boot_q <= boot_q + BOOT_W'(1);
            end
            wa_q        <= wa_d;
            wd_q        <= wd_d;
            w_adr_q     <= w_adr_d;
            w_data_q    <= w_data_d;
            r_adr_q     <= r_adr_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
            do_write_q  <= do_write_d;
            rd_entry_q  <= rd_entry_d;
            do_read_q   <= rd_entry_q;   // r_adr leads do_read by one cycle
            proto_err_q <= proto_err_d;
        end
    end

    // ---------------- outputs ----------------
    assign bus.r_adr     = r_adr_q;
    assign bus.w_adr     = w_adr_q;
    assign bus.w_data    = w_data_q;
    assign bus.do_write  = do_write_q;
    assign bus.do_read   = do_read_q;
    assign bus.proto_err = proto_err_q;
    assign bus.d_out     = d_out_q;
    // Contention guard: never drive the pads while the master is writing.
    assign bus.d_oe      = d_oe_q & s_nwe;

endmodule

// File: tb/tb_fsmc_sync_slave.sv
// ---------------------------------------------------------------------------
// tb_fsmc_sync_slave
//   Directed bench for fsmc_sync_slave (SYNC_STAGES = 2). A table of bus
//   cycles with hand-computed results is replayed, followed by hand-written
//   sequences for illegal strobes, reset mid-write and back-to-back cycles.
//   Inputs change on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_fsmc_sync_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fsmc_sync_slave_if #(.ADRW(8), .DATW(16)) bus ();

    fsmc_sync_slave #(.ADRW(8), .DATW(16), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register decoder model: combinational read data from r_adr.
    assign bus.r_data = (bus.r_adr == 8'h01) ? 16'h0ABC : {8'hA5, bus.r_adr};

    typedef struct {
        logic        wr;
        logic [7:0]  adr;
        logic [15:0] d1;        // data for the first half of a write
        logic [15:0] d2;        // data for the second half of a write
        logic [7:0]  exp_adr;
        logic [15:0] exp_data;  // w_data for writes, d_out for reads
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_write(input logic [7:0] a, input logic [15:0] d1, input logic [15:0] d2,
                             input logic [7:0] ea, input logic [15:0] ed);
        int n_wr, first, oe_seen, perr;
        logic [7:0]  got_a;
        logic [15:0] got_d;
        n_wr = 0; first = -1; oe_seen = 0; perr = 0; got_a = '0; got_d = '0;
        bus.aA = a; bus.aD_in = d1; bus.aNE = 1'b0; bus.aNWE = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) bus.aD_in = d2;
            tick();
            if (bus.do_write) n_wr++;
            if (bus.d_oe) oe_seen++;
            if (bus.proto_err) perr++;
        end
        bus.aNWE = 1'b1; bus.aNE = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (bus.do_write) begin
                n_wr++;
                if (first < 0) first = k;
                got_a = bus.w_adr;
                got_d = bus.w_data;
            end
            if (bus.d_oe) oe_seen++;
            if (bus.proto_err) perr++;
        end
        check("wr_count",   32'(n_wr), 32'd1);
        check("wr_latency", 32'(first), 32'd3);
        check("wr_adr",     32'(got_a), 32'(ea));
        check("wr_data",    32'(got_d), 32'(ed));
        check("wr_adr_hold", 32'(bus.w_adr), 32'(ea));
        check("wr_no_oe",   32'(oe_seen), 32'd0);
        check("wr_no_perr", 32'(perr), 32'd0);
    endtask

    task automatic run_read(input logic [7:0] a, input logic [7:0] ea, input logic [15:0] ed);
        int oe_rise, oe_fall, n_rd, rd_at, perr, n_wr;
        logic [7:0]  got_a;
        logic [15:0] dout4;
        oe_rise = -1; oe_fall = -1; n_rd = 0; rd_at = -1; perr = 0; n_wr = 0;
        got_a = '0; dout4 = '0;
        bus.aA = a; bus.aNE = 1'b0; bus.aNOE = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (bus.d_oe && oe_rise < 0) oe_rise = k;
            if (k == 4) dout4 = bus.d_out;
            if (bus.do_read) begin n_rd++; rd_at = k; got_a = bus.r_adr; end
            if (bus.proto_err) perr++;
            if (bus.do_write) n_wr++;
        end
        bus.aNOE = 1'b1; bus.aNE = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (!bus.d_oe && oe_fall < 0) oe_fall = k;
            if (bus.do_read) n_rd++;
            if (bus.proto_err) perr++;
            if (bus.do_write) n_wr++;
        end
        check("rd_oe_rise", 32'(oe_rise), 32'd3);
        check("rd_dout_clk4", 32'(dout4), 32'(ed));
        check("rd_count",   32'(n_rd), 32'd1);
        check("rd_strobe_at", 32'(rd_at), 32'd4);
        check("rd_adr",     32'(got_a), 32'(ea));
        check("rd_oe_fall", 32'(oe_fall), 32'd3);
        check("rd_no_perr", 32'(perr), 32'd0);
        check("rd_no_write", 32'(n_wr), 32'd0);
    endtask

    initial begin
        int n_wr, n_rd, n_perr, perr_at, oe_seen, overlap, wr_at, oe_at, j;
        logic [15:0] got_d;

        vecs[0] = '{wr: 1'b1, adr: 8'h02, d1: 16'hBEEF, d2: 16'hBEEF, exp_adr: 8'h02, exp_data: 16'hBEEF};
        vecs[1] = '{wr: 1'b0, adr: 8'h01, d1: 16'h0000, d2: 16'h0000, exp_adr: 8'h01, exp_data: 16'h0ABC};
        vecs[2] = '{wr: 1'b1, adr: 8'h10, d1: 16'h1111, d2: 16'h2222, exp_adr: 8'h10, exp_data: 16'h2222};
        vecs[3] = '{wr: 1'b0, adr: 8'h7F, d1: 16'h0000, d2: 16'h0000, exp_adr: 8'h7F, exp_data: 16'hA57F};
        vecs[4] = '{wr: 1'b1, adr: 8'hFF, d1: 16'h8001, d2: 16'h8001, exp_adr: 8'hFF, exp_data: 16'h8001};
        vecs[5] = '{wr: 1'b0, adr: 8'hFF, d1: 16'h0000, d2: 16'h0000, exp_adr: 8'hFF, exp_data: 16'hA5FF};

        bus.aNE = 1'b1; bus.aNOE = 1'b1; bus.aNWE = 1'b1;
        bus.aA = '0; bus.aD_in = '0;

        // ---- reset state ----
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_do_write", 32'(bus.do_write), 32'd0);
        check("rst_do_read",  32'(bus.do_read), 32'd0);
        check("rst_perr",     32'(bus.proto_err), 32'd0);
        check("rst_d_oe",     32'(bus.d_oe), 32'd0);
        check("rst_d_out",    32'(bus.d_out), 32'd0);
        check("rst_w_adr",    32'(bus.w_adr), 32'd0);
        check("rst_w_data",   32'(bus.w_data), 32'd0);
        check("rst_r_adr",    32'(bus.r_adr), 32'd0);
        repeat (3) tick();

        // ---- table-driven bus cycles ----
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].wr)
                run_write(vecs[i].adr, vecs[i].d1, vecs[i].d2, vecs[i].exp_adr, vecs[i].exp_data);
            else
                run_read(vecs[i].adr, vecs[i].exp_adr, vecs[i].exp_data);
            tick();
        end

        // ---- aNOE and aNWE low together ----
        n_wr = 0; n_rd = 0; n_perr = 0; perr_at = -1; oe_seen = 0;
        bus.aA = 8'h33; bus.aNE = 1'b0; bus.aNOE = 1'b0; bus.aNWE = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (bus.proto_err) begin n_perr++; if (perr_at < 0) perr_at = k; end
            if (bus.do_write) n_wr++;
            if (bus.do_read) n_rd++;
            if (bus.d_oe) oe_seen++;
        end
        bus.aNOE = 1'b1;   // NWE still low: must keep waiting
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (bus.proto_err) n_perr++;
            if (bus.do_write) n_wr++;
            if (bus.do_read) n_rd++;
            if (bus.d_oe) oe_seen++;
        end
        bus.aNWE = 1'b1; bus.aNE = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (bus.proto_err) n_perr++;
            if (bus.do_write) n_wr++;
            if (bus.do_read) n_rd++;
            if (bus.d_oe) oe_seen++;
        end
        check("perr_count", 32'(n_perr), 32'd1);
        check("perr_at",    32'(perr_at), 32'd3);
        check("perr_no_write", 32'(n_wr), 32'd0);
        check("perr_no_read",  32'(n_rd), 32'd0);
        check("perr_no_oe",    32'(oe_seen), 32'd0);
        run_read(8'h01, 8'h01, 16'h0ABC);   // recovers after release
        tick();

        // ---- reset in the middle of a write ----
        bus.aA = 8'h44; bus.aD_in = 16'h4444; bus.aNE = 1'b0; bus.aNWE = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("midrst_do_write", 32'(bus.do_write), 32'd0);
        check("midrst_w_adr",    32'(bus.w_adr), 32'd0);
        check("midrst_w_data",   32'(bus.w_data), 32'd0);
        check("midrst_r_adr",    32'(bus.r_adr), 32'd0);
        check("midrst_d_out",    32'(bus.d_out), 32'd0);
        tick();
        rst = 1'b0;
        n_wr = 0; n_perr = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (bus.do_write) n_wr++;
            if (bus.proto_err) n_perr++;
        end
        bus.aNWE = 1'b1; bus.aNE = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (bus.do_write) n_wr++;
            if (bus.proto_err) n_perr++;
        end
        check("midrst_no_write", 32'(n_wr), 32'd0);
        check("midrst_no_perr",  32'(n_perr), 32'd0);
        run_write(8'h55, 16'h5A5A, 16'h5A5A, 8'h55, 16'h5A5A);
        tick();

        // ---- back-to-back write then read, 1 clk turnaround ----
        n_wr = 0; n_rd = 0; overlap = 0; wr_at = -1; oe_at = -1; j = 0; got_d = '0;
        bus.aA = 8'h20; bus.aD_in = 16'hC0DE; bus.aNE = 1'b0; bus.aNWE = 1'b0;
        for (int k = 0; k < 21; k++) begin
            if (k == 6) begin bus.aNWE = 1'b1; bus.aNE = 1'b1; end
            if (k == 7) begin bus.aA = 8'h01; bus.aNE = 1'b0; bus.aNOE = 1'b0; end
            if (k == 15) begin bus.aNOE = 1'b1; bus.aNE = 1'b1; end
            tick();
            j++;
            if (bus.do_write) begin n_wr++; wr_at = j; got_d = bus.w_data; end
            if (bus.do_read) n_rd++;
            if (bus.d_oe && oe_at < 0) oe_at = j;
            if (bus.d_oe && !bus.aNWE) overlap++;
            if (k == 14) check("b2b_d_out", 32'(bus.d_out), 32'h0ABC);
        end
        check("b2b_write_count", 32'(n_wr), 32'd1);
        check("b2b_w_data",      32'(got_d), 32'hC0DE);
        check("b2b_read_count",  32'(n_rd), 32'd1);
        check("b2b_turnaround",  32'(oe_at - wr_at), 32'd1);
        check("b2b_no_overlap",  32'(overlap), 32'd0);
        check("b2b_oe_released", 32'(bus.d_oe), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
